ball_control: RTL
=================

// Module: ball_control
// PURPOSE
//  Control FSM for the ball datapath. Sequences each animation frame:
//  draw ball -> wait one frame period -> erase ball -> wall/paddle collision check -> move one step.
//  Consumes the datapath's x, y, h_q, v_q and drives its en_counters, h_t, v_t and sel_c.
//  Emits per-pixel plot strobes and coordinates for the VGA adapter; flags game_over on a missed paddle.
// PARAMETERS
//  BALL_SIZE  2       ball edge length in pixels (square ball)
//  X_MIN      0       leftmost legal x of ball top-left
//  X_MAX      159     rightmost legal pixel column
//  Y_MIN      0       topmost legal y of ball top-left
//  Y_MAX      119     bottom pixel row; reaching it means the paddle was missed
//  PADDLE_Y   116     row of the paddle's top edge
//  PADDLE_W   16      paddle width in pixels
//  FRAME_DIV  833333  clock cycles spent in WAIT (60 Hz at 50 MHz)
// PORTS
//  clock         in   1   system clock
//  reset_counts  in   1   reset, asynchronous, active-low; shared with the ball datapath
//  go            in   1   start animation (sampled in IDLE only)
//  x             in   8   ball top-left x from datapath
//  y             in   7   ball top-left y from datapath
//  h_q           in   1   horizontal direction from datapath (1 = +x)
//  v_q           in   1   vertical direction from datapath (1 = +y)
//  paddle_x      in   8   paddle left edge x
//  en_counters   out  1   one-cycle step enable to datapath
//  h_t           out  1   one-cycle horizontal toggle pulse
//  v_t           out  1   one-cycle vertical toggle pulse
//  sel_c         out  1   1 = ball colour, 0 = background colour
//  plot          out  1   pixel write strobe
//  px_x          out  8   pixel x = x + ox
//  px_y          out  7   pixel y = y + oy
//  game_over     out  1   high in OVER state
//  busy          out  1   high in any state except IDLE and OVER
// BEHAVIOUR
//  Reset
//  - Async reset, active-low: state=IDLE, ox=oy=0, frame counter=0.
//  - All outputs 0 during and after reset, until go.
//  IDLE
//  - All strobes 0.
//  - go=1 -> DRAW.
//  DRAW
//  - sel_c=1, plot=1 every cycle.
//  - (ox,oy) raster scan: ox fastest, both 0..BALL_SIZE-1.
//  - Lasts exactly BALL_SIZE^2 cycles; after the last pixel: offsets clear, -> WAIT.
//  WAIT
//  - plot=0.
//  - Counts FRAME_DIV cycles, then clears the counter and -> ERASE.
//  ERASE
//  - Same scan as DRAW but sel_c=0.
//  - Lasts BALL_SIZE^2 cycles, then -> CHECK.
//  CHECK (one cycle)
//  - h_t=1 if (h_q & x+BALL_SIZE-1>=X_MAX) | (!h_q & x<=X_MIN).
//  - v_t=1 if (!v_q & y<=Y_MIN) | paddle hit.
//  - Paddle hit = v_q & y+BALL_SIZE==PADDLE_Y & x+BALL_SIZE-1>=paddle_x & x<=paddle_x+PADDLE_W-1.
//  - h_t and v_t may assert in the same cycle (corner bounce).
//  - Exit: if v_q & y+BALL_SIZE-1>=Y_MAX -> OVER (no toggles); else -> MOVE.
//  MOVE (one cycle)
//  - en_counters=1, then -> DRAW.
//  - Datapath flops toggle at the CHECK->MOVE edge, so MOVE steps in the updated direction.
//  OVER
//  - game_over=1, all strobes 0.
//  - Held until reset_counts; go is ignored.
//  General
//  - go is ignored outside IDLE.
//  - Frame period = 2*BALL_SIZE^2 + FRAME_DIV + 2 cycles.
//  - Compares use 9-bit x / 8-bit y so that +BALL_SIZE and +PADDLE_W never wrap.
//  - h_t, v_t, en_counters: never high for more than one cycle, and never outside CHECK/MOVE.
// TESTING
//  Bench parameters: FRAME_DIV=4, BALL_SIZE=2.
//  1. Reset then go; datapath at x=0,y=34,h_q=0,v_q=0
//     -> plot 4 cycles at (0,34)(1,34)(0,35)(1,35) with sel_c=1
//     -> 4 idle cycles -> same 4 pixels with sel_c=0
//     -> h_t=1, v_t=0 in CHECK -> en_counters=1 the next cycle.
//  2. x=158,h_q=1,y=60,v_q=1 -> CHECK: h_t=1, v_t=0.
//     x=0,h_q=0,y=0,v_q=0 -> CHECK: h_t=1 and v_t=1 in the same cycle.
//  3. paddle_x=50, x=60, y=114, v_q=1 -> v_t=1, next state MOVE.
//     Same with paddle_x=100 -> v_t=0, ball continues down.
//  4. y=118, v_q=1, paddle missed -> CHECK goes to OVER: game_over=1, en_counters stays 0, go ignored.
//  5. Drop reset_counts mid-DRAW (2nd pixel) -> plot/sel_c drop immediately; IDLE after release.
//  6. Free-run 3 frames -> exactly one en_counters pulse per 14 cycles; busy=1 throughout.

Source files
------------

// File: rtl/ball_control.sv
// Ball animation sequencer: draw, wait a frame, erase, bounce check, step.
// Drives the ball datapath and the VGA pixel-plot port.
module ball_control #(
  parameter int BALL_SIZE = 2,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 159,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 119,
  parameter int PADDLE_Y  = 116,
  parameter int PADDLE_W  = 16,
  parameter int FRAME_DIV = 833333
) (
  input  logic       clock,
  input  logic       reset_counts,
  input  logic       go,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic       h_q,
  input  logic       v_q,
  input  logic [7:0] paddle_x,
  output logic       en_counters,
  output logic       h_t,
  output logic       v_t,
  output logic       sel_c,
  output logic       plot,
  output logic [7:0] px_x,
  output logic [6:0] px_y,
  output logic       game_over,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_WAIT,
    S_ERASE,
    S_CHECK,
    S_MOVE,
    S_OVER
  } state_t;

  localparam int OW = (BALL_SIZE > 1) ? $clog2(BALL_SIZE) : 1;
  localparam int CW = $clog2(FRAME_DIV + 1);

  localparam logic [OW-1:0] OMAX = OW'(BALL_SIZE - 1);
  localparam logic [CW-1:0] CMAX = CW'(FRAME_DIV - 1);

  localparam logic [8:0] XMIN9 = 9'(X_MIN);
  localparam logic [8:0] XMAX9 = 9'(X_MAX);
  localparam logic [8:0] BSX9  = 9'(BALL_SIZE);
  localparam logic [8:0] PW9   = 9'(PADDLE_W);
  localparam logic [7:0] YMIN8 = 8'(Y_MIN);
  localparam logic [7:0] YMAX8 = 8'(Y_MAX);
  localparam logic [7:0] BSY8  = 8'(BALL_SIZE);
  localparam logic [7:0] PY8   = 8'(PADDLE_Y);

  state_t        state, state_n;
  logic [OW-1:0] ox, ox_n, oy, oy_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [8:0] x9, px9, x_right;
  logic [7:0] y8, y_bot;
  logic       last_px;
  logic [OW-1:0] scan_ox, scan_oy;
  logic       hit_r, hit_l, hit_t, paddle_hit, missed;

  // Widened operands so +BALL_SIZE / +PADDLE_W never wrap
  assign x9      = {1'b0, x};
  assign px9     = {1'b0, paddle_x};
  assign y8      = {1'b0, y};
  assign x_right = x9 + BSX9 - 9'd1;
  assign y_bot   = y8 + BSY8 - 8'd1;

  assign hit_r = h_q & (x_right >= XMAX9);
  assign hit_l = ~h_q & (x9 <= XMIN9);
  assign hit_t = ~v_q & (y8 <= YMIN8);

  assign paddle_hit = v_q
    & ((y8 + BSY8) == PY8)
    & (x_right >= px9)
    & (x9 <= (px9 + PW9 - 9'd1));

  assign missed = v_q & (y_bot >= YMAX8);

  assign last_px = (ox == OMAX) && (oy == OMAX);

  always_comb begin
    scan_ox = ox + OW'(1);
    scan_oy = oy;
    if (ox == OMAX) begin
      scan_ox = '0;
      scan_oy = last_px ? '0 : oy + OW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_counts) begin
    if (!reset_counts) begin
      state <= S_IDLE;
      ox    <= '0;
      oy    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ox    <= ox_n;
      oy    <= oy_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    ox_n        = ox;
    oy_n        = oy;
    cnt_n       = cnt;
    en_counters = 1'b0;
    h_t         = 1'b0;
    v_t         = 1'b0;
    sel_c       = 1'b0;
    plot        = 1'b0;
    game_over   = 1'b0;
    busy        = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) state_n = S_DRAW;
      end
      S_DRAW: begin
        sel_c = 1'b1;
        plot  = 1'b1;
        ox_n  = scan_ox;
        oy_n  = scan_oy;
        if (last_px) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == CMAX) begin
          cnt_n   = '0;
          state_n = S_ERASE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_ERASE: begin
        plot = 1'b1;
        ox_n = scan_ox;
        oy_n = scan_oy;
        if (last_px) state_n = S_CHECK;
      end
      S_CHECK: begin
        // A missed paddle ends the game without bouncing
        if (missed) begin
          state_n = S_OVER;
        end else begin
          h_t     = hit_r | hit_l;
          v_t     = hit_t | paddle_hit;
          state_n = S_MOVE;
        end
      end
      S_MOVE: begin
        en_counters = 1'b1;
        state_n     = S_DRAW;
      end
      S_OVER: begin
        busy      = 1'b0;
        game_over = 1'b1;
      end
      default: begin
        busy    = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign px_x = plot ? (x + 8'(ox)) : 8'd0;
  assign px_y = plot ? (y + 7'(oy)) : 7'd0;

endmodule
